shake_input_loader: RTL and testbench

Input-side stage of the SHAKE core. It accepts message words from the upstream producer over a valid/ready handshake and assembles them into one rate-sized block. It applies SHAKE pad10*1 padding with the domain-separation byte and hands each completed block to the absorb/permutation stage through a block-level valid/ready handshake. It is the receiving counterpart of the output dump stage.

---
 rtl/shake_pkg.sv | 18 +
 rtl/shake_pad_word.sv | 30 +++
 rtl/shake_input_loader.sv | 149 ++++++++++++++
 tb/tb_shake_input_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared constants and types for the SHAKE core: rate sizes, padding bytes
// and the input loader state encoding.
package shake_pkg;

  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;

  localparam logic [7:0] DOMAIN_BYTE  = 8'h1F;
  localparam logic [7:0] PAD_END_BYTE = 8'h80;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_FILL = 2'd1,
    LD_PAD  = 2'd2,
    LD_HOLD = 2'd3
  } loader_state_e;

endpackage

// File: rtl/shake_pad_word.sv
// Combinational pad10*1 word shaper: keeps the first valid_bytes bytes, drops
// the domain byte right after them, and/or ORs the end marker into byte 7.
import shake_pkg::*;

module shake_pad_word #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0] word_in,
  input  logic [3:0]        valid_bytes,
  input  logic              insert_domain,
  input  logic              insert_end,
  output logic [WORD_W-1:0] word_out
);

  always_comb begin
    word_out = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      if (b < int'(valid_bytes)) begin
        word_out[8*b +: 8] = word_in[8*b +: 8];
      end else if (insert_domain && (b == int'(valid_bytes))) begin
        word_out[8*b +: 8] = DOMAIN_BYTE;
      end
    end
    // The end marker shares byte 7 with the domain byte when v = 7 (0x9F).
    if (insert_end) begin
      word_out[WORD_W-1 -: 8] = word_out[WORD_W-1 -: 8] | PAD_END_BYTE;
    end
  end

endmodule

// File: rtl/shake_input_loader.sv
// SHAKE input loader: collects message words into one rate-sized block,
// applies pad10*1 with the domain byte and hands blocks to the absorb stage.
import shake_pkg::*;

module shake_input_loader #(
  parameter int WORD_W         = 64,
  parameter int MAX_RATE_WORDS = 21
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mode_in,
  input  logic [WORD_W-1:0]                  data_in,
  input  logic                               valid_in,
  input  logic                               last_in,
  input  logic [3:0]                         valid_bytes_in,
  output logic                               ready_out,
  output logic [MAX_RATE_WORDS*WORD_W-1:0]   block_out,
  output logic                               block_valid_out,
  output logic                               last_block_out,
  input  logic                               block_ready_in
);

  localparam logic [4:0] RATE128_M1 = 5'(RATE128_WORDS - 1);
  localparam logic [4:0] RATE256_M1 = 5'(RATE256_WORDS - 1);

  loader_state_e     state_q;
  logic [4:0]        wcnt_q;
  logic [4:0]        rate_m1_q;
  logic              pend_q;
  logic              last_q;
  logic [WORD_W-1:0] blk_q [MAX_RATE_WORDS];

  logic              accept;
  logic [4:0]        cur_rate_m1;
  logic              at_end;
  logic              short_last;
  logic [3:0]        clamped_vb;
  logic [WORD_W-1:0] pw_word;
  logic [3:0]        pw_vb;
  logic              pw_dom;
  logic              pw_end;
  logic [WORD_W-1:0] pw_out;

  assign ready_out       = (state_q == LD_IDLE) || (state_q == LD_FILL);
  assign block_valid_out = (state_q == LD_HOLD);
  assign last_block_out  = (state_q == LD_HOLD) && last_q;
  assign accept          = valid_in && ready_out;

  // In IDLE the rate is not latched yet, so the first word sees mode_in directly.
  assign cur_rate_m1 = (state_q == LD_IDLE) ? (mode_in ? RATE256_M1 : RATE128_M1) : rate_m1_q;
  assign at_end      = (wcnt_q == cur_rate_m1);
  assign clamped_vb  = (valid_bytes_in > 4'd8) ? 4'd8 : valid_bytes_in;
  assign short_last  = last_in && (clamped_vb < 4'd8);

  always_comb begin
    pw_word = data_in;
    pw_vb   = last_in ? clamped_vb : 4'd8;
    pw_dom  = short_last;
    pw_end  = short_last && at_end;
    if (state_q == LD_PAD) begin
      pw_word = '0;
      pw_vb   = 4'd0;
      pw_dom  = pend_q;
      pw_end  = at_end;
    end
  end

  shake_pad_word #(
    .WORD_W(WORD_W)
  ) u_pad_word (
    .word_in      (pw_word),
    .valid_bytes  (pw_vb),
    .insert_domain(pw_dom),
    .insert_end   (pw_end),
    .word_out     (pw_out)
  );

  always_comb begin
    for (int i = 0; i < MAX_RATE_WORDS; i++) begin
      block_out[i*WORD_W +: WORD_W] = blk_q[i];
    end
  end

  // State, counter, flags and block register share one sequential process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LD_IDLE;
      wcnt_q    <= '0;
      rate_m1_q <= RATE128_M1;
      pend_q    <= 1'b0;
      last_q    <= 1'b0;
      for (int i = 0; i < MAX_RATE_WORDS; i++) begin
        blk_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LD_IDLE, LD_FILL: begin
          if (accept) begin
            if (state_q == LD_IDLE) begin
              rate_m1_q <= cur_rate_m1;
            end
            blk_q[wcnt_q] <= pw_out;
            wcnt_q        <= wcnt_q + 5'd1;
            if (!last_in) begin
              last_q  <= 1'b0;
              state_q <= at_end ? LD_HOLD : LD_FILL;
            end else if (short_last) begin
              pend_q  <= 1'b0;
              last_q  <= at_end;
              state_q <= at_end ? LD_HOLD : LD_PAD;
            end else begin
              // Full final word: the domain byte spills into the next word.
              pend_q  <= 1'b1;
              last_q  <= 1'b0;
              state_q <= at_end ? LD_HOLD : LD_PAD;
            end
          end
        end
        LD_PAD: begin
          blk_q[wcnt_q] <= pw_out;
          wcnt_q        <= wcnt_q + 5'd1;
          pend_q        <= 1'b0;
          if (at_end) begin
            last_q  <= 1'b1;
            state_q <= LD_HOLD;
          end
        end
        LD_HOLD: begin
          if (block_ready_in) begin
            wcnt_q <= '0;
            for (int i = 0; i < MAX_RATE_WORDS; i++) begin
              blk_q[i] <= '0;
            end
            if (last_q) begin
              last_q  <= 1'b0;
              state_q <= LD_IDLE;
            end else if (pend_q) begin
              state_q <= LD_PAD;
            end else begin
              state_q <= LD_FILL;
            end
          end
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_input_loader.sv
// Directed bench for shake_input_loader: full blocks, padding corner cases,
// HOLD back-pressure and mid-message reset.
module tb_shake_input_loader;

  localparam int BW = 21 * 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_in;
  logic [63:0]   data_in;
  logic          valid_in;
  logic          last_in;
  logic [3:0]    valid_bytes_in;
  logic          ready_out;
  logic [BW-1:0] block_out;
  logic          block_valid_out;
  logic          last_block_out;
  logic          block_ready_in;

  int            total = 0;
  int            bad   = 0;
  int            n;
  logic [BW-1:0] exp_blk;

  always #5 clk = ~clk;

  shake_input_loader dut (
    .clk            (clk),
    .rst            (rst),
    .mode_in        (mode_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .last_in        (last_in),
    .valid_bytes_in (valid_bytes_in),
    .ready_out      (ready_out),
    .block_out      (block_out),
    .block_valid_out(block_valid_out),
    .last_block_out (last_block_out),
    .block_ready_in (block_ready_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] req);
    int w;
    w = -1;
    for (int i = 0; i < 21; i++) begin
      if (w < 0 && block_out[64*i +: 64] !== req[64*i +: 64]) w = i;
    end
    if (w < 0) w = 0;
    total++;
    assert (block_out === req) else begin
      bad++;
      $error("FAIL %s word%0d observed=%h expected=%h", tag, w, block_out[64*w +: 64], req[64*w +: 64]);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic lst, input logic [3:0] vb, input logic md);
    data_in        = d;
    last_in        = lst;
    valid_bytes_in = vb;
    mode_in        = md;
    valid_in       = 1'b1;
    chk("ready_before_word", {63'd0, ready_out}, 64'd1);
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 1;
    while (block_valid_out !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic handoff();
    block_ready_in = 1'b1;
    tick();
    block_ready_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode_in = 1'b0; data_in = '0; valid_in = 1'b0;
    last_in = 1'b0; valid_bytes_in = 4'd0; block_ready_in = 1'b0;
    tick();
    tick();
    chk("rst_ready", {63'd0, ready_out}, 64'd1);
    chk("rst_valid", {63'd0, block_valid_out}, 64'd0);
    chk("rst_last", {63'd0, last_block_out}, 64'd0);
    chk_blk("rst_block", '0);
    rst = 1'b0;

    // SHAKE128, 21 full words, none last
    exp_blk = '0;
    for (int i = 0; i < 21; i++) begin
      exp_blk[64*i +: 64] = 64'h0101_0101_0101_0101 * i;
      send(64'h0101_0101_0101_0101 * i, 1'b0, 4'd0, 1'b0);
      if (i == 19) chk("full_not_early", {63'd0, block_valid_out}, 64'd0);
    end
    chk("full_valid", {63'd0, block_valid_out}, 64'd1);
    chk("full_last", {63'd0, last_block_out}, 64'd0);
    chk("full_ready_low", {63'd0, ready_out}, 64'd0);
    chk_blk("full_block", exp_blk);

    // back-pressure in HOLD with valid_in asserted
    data_in = 64'hDEAD_BEEF_0000_0001;
    valid_in = 1'b1;
    repeat (10) tick();
    chk("stall_valid", {63'd0, block_valid_out}, 64'd1);
    chk("stall_ready", {63'd0, ready_out}, 64'd0);
    chk_blk("stall_block", exp_blk);
    valid_in = 1'b0;
    handoff();
    chk("handoff_valid", {63'd0, block_valid_out}, 64'd0);
    chk("handoff_ready", {63'd0, ready_out}, 64'd1);
    chk_blk("handoff_clear", '0);

    // continuing message: short last word lands at wcnt 0
    send(64'h1122_3344_5566_7788, 1'b1, 4'd2, 1'b1);
    wait_valid(n);
    chk("cont_latency", 64'(n), 64'd21);
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000_0000_001F_7788;
    exp_blk[64*20 +: 64] = 64'h8000_0000_0000_0000;
    chk_blk("cont_block", exp_blk);
    chk("cont_last", {63'd0, last_block_out}, 64'd1);
    handoff();
    chk("cont_idle_ready", {63'd0, ready_out}, 64'd1);

    // SHAKE256 empty message
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 1'b1);
    wait_valid(n);
    chk("empty256_latency", 64'(n), 64'd17);
    exp_blk = '0;
    exp_blk[63:0] = 64'h1F;
    exp_blk[64*16 +: 64] = 64'h8000_0000_0000_0000;
    chk_blk("empty256_block", exp_blk);
    chk("empty256_last", {63'd0, last_block_out}, 64'd1);
    handoff();

    // SHAKE128, 3 words, last v=3
    send(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 4'd0, 1'b0);
    send(64'h0123_4567_89AB_CDEF, 1'b0, 4'd0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, 1'b0);
    wait_valid(n);
    chk("short128_latency", 64'(n), 64'd19);
    exp_blk = '0;
    exp_blk[63:0]   = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_blk[127:64] = 64'h0123_4567_89AB_CDEF;
    exp_blk[191:128] = 64'h0000_0000_1FFF_FFFF;
    exp_blk[64*20 +: 64] = 64'h8000_0000_0000_0000;
    chk_blk("short128_block", exp_blk);
    chk("short128_last", {63'd0, last_block_out}, 64'd1);
    handoff();

    // SHAKE128, 21 words, last v=8 -> extra padding block
    exp_blk = '0;
    for (int i = 0; i < 21; i++) begin
      exp_blk[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
      send(64'hA5A5_0000_0000_0000 | 64'(i), (i == 20), 4'd8, 1'b0);
    end
    chk("v8_first_valid", {63'd0, block_valid_out}, 64'd1);
    chk("v8_first_last", {63'd0, last_block_out}, 64'd0);
    chk_blk("v8_first_block", exp_blk);
    handoff();
    wait_valid(n);
    chk("v8_second_latency", 64'(n), 64'd22);
    exp_blk = '0;
    exp_blk[63:0] = 64'h1F;
    exp_blk[64*20 +: 64] = 64'h8000_0000_0000_0000;
    chk_blk("v8_second_block", exp_blk);
    chk("v8_second_last", {63'd0, last_block_out}, 64'd1);
    handoff();

    // SHAKE128, 21 words, last v=7 -> 0x9F in byte 7, single block
    exp_blk = '0;
    for (int i = 0; i < 20; i++) begin
      exp_blk[64*i +: 64] = 64'h5A00_0000_0000_0000 | 64'(i);
      send(64'h5A00_0000_0000_0000 | 64'(i), 1'b0, 4'd0, 1'b0);
    end
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd7, 1'b0);
    exp_blk[64*20 +: 64] = 64'h9FFF_FFFF_FFFF_FFFF;
    chk("v7_valid", {63'd0, block_valid_out}, 64'd1);
    chk("v7_last", {63'd0, last_block_out}, 64'd1);
    chk_blk("v7_block", exp_blk);
    handoff();
    chk("v7_after_valid", {63'd0, block_valid_out}, 64'd0);
    chk("v7_after_ready", {63'd0, ready_out}, 64'd1);

    // reset mid-FILL, then a SHAKE256 message
    for (int i = 0; i < 5; i++) send(64'hCAFE_0000_0000_0000 | 64'(i), 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {63'd0, ready_out}, 64'd1);
    chk("midrst_valid", {63'd0, block_valid_out}, 64'd0);
    chk("midrst_last", {63'd0, last_block_out}, 64'd0);
    chk_blk("midrst_block", '0);
    exp_blk = '0;
    for (int i = 0; i < 17; i++) begin
      exp_blk[64*i +: 64] = 64'h100 + 64'(i);
      send(64'h100 + 64'(i), 1'b0, 4'd0, (i == 0));
      if (i == 15) chk("r256_not_early", {63'd0, block_valid_out}, 64'd0);
    end
    chk("r256_valid", {63'd0, block_valid_out}, 64'd1);
    chk("r256_last", {63'd0, last_block_out}, 64'd0);
    chk_blk("r256_block", exp_blk);
    handoff();
    chk("r256_after_ready", {63'd0, ready_out}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
